// File: rtl/uart_seq_pkg.sv
// Shared types and CSR register map for the op_uart stream sequencer.
package uart_seq_pkg;

    localparam int CSR_AW = 14;

    localparam logic [CSR_AW-1:0] REG_RXTX = 14'h0;
    localparam logic [CSR_AW-1:0] REG_THRU = 14'h2;

    typedef enum logic [2:0] {
        IDLE,
        THRU,
        FETCH,
        MWAIT,
        WRITE,
        WAIT_TX,
        GAP,
        DONE
    } state_e;

endpackage

// File: rtl/uart_stream_sequencer_if.sv
// ROM read port plus op_uart CSR port, seen from the sequencer (master)
// and from the ROM/op_uart side (slave).
interface uart_stream_sequencer_if #(
    parameter int ADDR_W = 12
);
    import uart_seq_pkg::*;

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [CSR_AW-1:0] csr_a;
    logic              csr_we;
    logic [31:0]       csr_di;
    logic [31:0]       csr_do;
    logic              tx_irq;
    logic              rx_irq;

    modport master (
        output mem_rd, mem_addr, csr_a, csr_we, csr_di,
        input  mem_data, csr_do, tx_irq, rx_irq
    );

    modport slave (
        input  mem_rd, mem_addr, csr_a, csr_we, csr_di,
        output mem_data, csr_do, tx_irq, rx_irq
    );

endinterface

// File: rtl/uart_seq_rxcap.sv
// RX pending latch and two-cycle RXTX read: request cycle, then capture.
module uart_seq_rxcap (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rx_irq,
    input  logic       eligible,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    logic pending;
    logic rd_ph1;

    assign rd_req = pending & eligible & ~rd_ph1;
    assign busy   = rd_req | rd_ph1;

    // a new rx_irq wins over the clear so back-to-back bytes are not lost
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            rd_ph1   <= 1'b0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            if (rx_irq) begin
                pending <= 1'b1;
            end else if (rd_req) begin
                pending <= 1'b0;
            end
            rd_ph1   <= rd_req;
            rx_valid <= rd_ph1;
            if (rd_ph1) begin
                rx_byte <= rd_data;
            end
        end
    end

endmodule

// File: rtl/uart_stream_sequencer.sv
// Streams a ROM byte image into op_uart and services RX reads on the same port.
// Define UART_TX_TIMEOUT_EN to add the WAIT_TX watchdog driving err_to.
module uart_stream_sequencer
    import uart_seq_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int GAP_CYC = 100,
    parameter int TO_CYC  = 2**20
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_W:0]         len,
    input  logic                    set_thru,
    uart_stream_sequencer_if.master bus,
    output logic [7:0]              rx_byte,
    output logic                    rx_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err_to
);

    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   len_q;
    logic [7:0]        byte_q;
    logic [31:0]       gap_q;
    logic              tx_hold_q;
    logic              to_hit;
    logic              eligible;
    logic              rd_req;
    logic              rx_busy;
    logic              more;
    logic              tx_evt;
    logic              unused_hi;
    state_e            nxt;

    assign eligible  = (state_q == IDLE) || (state_q == WAIT_TX) ||
                       (state_q == GAP);
    assign more      = idx_q < len_q;
    assign nxt       = more ? FETCH : DONE;
    assign tx_evt    = bus.tx_irq | tx_hold_q;
    assign busy      = state_q != IDLE;
    assign bus.mem_addr = idx_q[ADDR_W-1:0];
    assign unused_hi = ^bus.csr_do[31:8];

    uart_seq_rxcap u_rxcap (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .rx_irq   (bus.rx_irq),
        .eligible (eligible),
        .rd_data  (bus.csr_do[7:0]),
        .rd_req   (rd_req),
        .busy     (rx_busy),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    always_comb begin
        state_d     = state_q;
        bus.mem_rd  = 1'b0;
        bus.csr_we  = 1'b0;
        bus.csr_a   = REG_RXTX;
        bus.csr_di  = 32'h0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (set_thru) begin
                        state_d = THRU;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            THRU: begin
                bus.csr_we = 1'b1;
                bus.csr_a  = REG_THRU;
                state_d    = FETCH;
            end
            FETCH: begin
                bus.mem_rd = 1'b1;
                state_d    = MWAIT;
            end
            MWAIT: begin
                state_d = WRITE;
            end
            WRITE: begin
                bus.csr_we = 1'b1;
                bus.csr_di = {24'h0, byte_q};
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (to_hit) begin
                    state_d = IDLE;
                end else if (tx_evt && !rx_busy) begin
                    state_d = (GAP_CYC == 0) ? nxt : GAP;
                end
            end
            GAP: begin
                if (gap_q == 32'(GAP_LAST) && !rx_busy) begin
                    state_d = nxt;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
        // RX read only runs in idle-bus states, so this never overrides a write
        if (rd_req && !bus.csr_we) begin
            bus.csr_a = REG_RXTX;
        end
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            byte_q    <= 8'h00;
            gap_q     <= 32'h0;
            tx_hold_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start && !abort) begin
                idx_q <= '0;
                len_q <= len;
            end
            if (state_q == MWAIT) begin
                byte_q <= bus.mem_data;
            end
            if (state_q == WRITE) begin
                idx_q <= idx_q + (ADDR_W+1)'(1);
            end
            if (state_q == GAP) begin
                if (gap_q != 32'(GAP_LAST)) begin
                    gap_q <= gap_q + 32'd1;
                end
            end else begin
                gap_q <= 32'h0;
            end
            // tx_irq landing during an RX read stall is held until exit
            tx_hold_q <= (state_q == WAIT_TX) && (state_d == WAIT_TX) &&
                         tx_evt;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    logic [31:0] to_q;
    logic        err_q;

    assign to_hit = (state_q == WAIT_TX) && !tx_evt &&
                    (to_q == 32'(TO_CYC - 1));
    assign err_to = err_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q  <= 32'h0;
            err_q <= 1'b0;
        end else begin
            to_q <= (state_q == WAIT_TX) ? to_q + 32'd1 : 32'h0;
            if (state_q == IDLE && start && !abort) begin
                err_q <= 1'b0;
            end else if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_to;

    assign unused_to = (TO_CYC == 0);
    assign to_hit    = 1'b0;
    assign err_to    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_stream_sequencer.sv
// Directed bench: ROM/op_uart responder, event-level scoreboard, literal checks.
module tb_uart_stream_sequencer;

    localparam int AW  = 4;
    localparam int GAP = 4;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          set_thru = 1'b0;
    logic [AW:0]   len = '0;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          busy;
    logic          done;
    logic          err_to;

    uart_stream_sequencer_if #(.ADDR_W(AW)) bus ();

    uart_stream_sequencer #(
        .ADDR_W  (AW),
        .GAP_CYC (GAP),
        .TO_CYC  (TO)
    ) dut (
        .sys_clk  (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .len      (len),
        .set_thru (set_thru),
        .bus      (bus),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .busy     (busy),
        .done     (done),
        .err_to   (err_to)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  rom [16];
    logic [7:0]  rx_data = 8'h00;
    int          tx_lat = 6;
    bit          tx_off = 1'b0;
    bit          gap_chk = 1'b0;

    logic [45:0] exp_wr [$];
    int          exp_addr [$];
    logic [7:0]  exp_rx [$];
    bit          exp_done [$];

    int cyc = 0;
    int last_irq_cyc = -1;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // The stream as the host should see it: optional THRU clear, then one
    // RXTX write per ROM byte in address order, then a single done.
    task automatic model_start(int n, bit thru);
        if (thru && n != 0) exp_wr.push_back({14'h2, 32'h0});
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_wr.push_back({14'h0, 24'h0, rom[i]});
        end
        exp_done.push_back(1'b1);
    endtask

    task automatic flush();
        exp_wr.delete();
        exp_addr.delete();
        exp_done.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(int n, bit thru);
        start = 1'b1;
        len = (AW+1)'(n);
        set_thru = thru;
        tick();
        start = 1'b0;
        model_start(n, thru);
    endtask

    task automatic wait_idle(int budget, string nm);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(busy), 32'(0));
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.tx_irq) last_irq_cyc <= cyc;
    end

    // ROM and op_uart responder: 1-cycle ROM data, registered csr_do,
    // tx_irq a fixed latency after each RXTX write.
    int              tx_cnt = 0;
    bit              rd_prev = 1'b0;
    bit              rq_prev = 1'b0;
    logic [AW-1:0]   rd_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.tx_irq   = 1'b0;
            bus.mem_data = 8'h00;
            bus.csr_do   = 32'h0;
            tx_cnt = 0;
            rd_prev = 1'b0;
            rq_prev = 1'b0;
        end else begin
            bus.tx_irq   = 1'b0;
            bus.mem_data = rd_prev ? rom[rd_addr] : 8'hEE;
            bus.csr_do   = rq_prev ? {24'h0, rx_data} : 32'h5A5A_5A5A;
            rd_prev = bus.mem_rd;
            rd_addr = bus.mem_addr;
            rq_prev = (bus.csr_a == 14'h0) && !bus.csr_we;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) bus.tx_irq = 1'b1;
            end
            if (bus.csr_we && bus.csr_a == 14'h0 && !tx_off) tx_cnt = tx_lat;
        end
    end

    // Single compare process over all observable DUT events.
    int used_irq = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_rd) begin
                chk("mem_rd expected", 32'(exp_addr.size() > 0), 32'(1));
                if (exp_addr.size() > 0)
                    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.csr_we) begin
                chk("csr_we expected", 32'(exp_wr.size() > 0), 32'(1));
                if (exp_wr.size() > 0) begin
                    logic [45:0] e;
                    e = exp_wr.pop_front();
                    chk("csr_a", 32'(bus.csr_a), 32'(e[45:32]));
                    chk("csr_di", bus.csr_di, e[31:0]);
                end
            end
            if (done) begin
                chk("done expected", 32'(exp_done.size() > 0), 32'(1));
                if (exp_done.size() > 0) void'(exp_done.pop_front());
            end
            if (rx_valid) begin
                chk("rx expected", 32'(exp_rx.size() > 0), 32'(1));
                if (exp_rx.size() > 0)
                    chk("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
            end
            if ((bus.mem_rd || done) && gap_chk && last_irq_cyc >= 0 &&
                last_irq_cyc != used_irq) begin
                chk("gap", 32'(cyc - last_irq_cyc), 32'(GAP + 1));
                used_irq = last_irq_cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        bus.rx_irq = 1'b0;
        rom[0] = 8'h13;
        rom[1] = 8'h37;
        rom[2] = 8'hA5;
        for (int i = 3; i < 16; i++) rom[i] = 8'(8'h40 + i * 3);

        tick();
        tick();
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst done", 32'(done), 32'(0));
        chk("rst csr_we", 32'(bus.csr_we), 32'(0));
        chk("rst csr_a", 32'(bus.csr_a), 32'(0));
        chk("rst mem_rd", 32'(bus.mem_rd), 32'(0));
        chk("rst mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst rx_valid", 32'(rx_valid), 32'(0));
        chk("rst rx_byte", 32'(rx_byte), 32'(0));
        chk("rst err_to", 32'(err_to), 32'(0));
        rst_n = 1'b1;
        tick();
        tick();

        // 1: THRU then three bytes, slow tx_irq, gap timing enforced
        tx_lat = 50;
        gap_chk = 1'b1;
        go(3, 1'b1);
        chk("t1 thru we", 32'(bus.csr_we), 32'(1));
        chk("t1 thru addr", 32'(bus.csr_a), 32'(2));
        k = 1;
        while (!(bus.csr_we && bus.csr_a == 14'h0) && k < 20) begin
            tick();
            k++;
        end
        chk("t1 first byte cycle", 32'(k), 32'(4));
        chk("t1 first byte data", bus.csr_di, 32'h13);
        wait_idle(600, "t1 idle");
        chk("t1 writes left", 32'(exp_wr.size()), 32'(0));
        chk("t1 done left", 32'(exp_done.size()), 32'(0));
        gap_chk = 1'b0;
        tick();

        // 2: zero length
        tx_lat = 6;
        go(0, 1'b0);
        chk("t2 done", 32'(done), 32'(1));
        tick();
        chk("t2 done width", 32'(done), 32'(0));
        chk("t2 idle", 32'(busy), 32'(0));

        // 3: rx_irq in the first GAP cycle
        rx_data = 8'hBA;
        go(3, 1'b0);
        k = 0;
        while (!bus.tx_irq && k < 100) begin
            tick();
            k++;
        end
        chk("t3 tx_irq seen", 32'(bus.tx_irq), 32'(1));
        bus.rx_irq = 1'b1;
        exp_rx.push_back(8'hBA);
        tick();
        bus.rx_irq = 1'b0;
        wait_idle(300, "t3 idle");
        chk("t3 rx left", 32'(exp_rx.size()), 32'(0));
        chk("t3 rx_byte", 32'(rx_byte), 32'hBA);
        chk("t3 writes left", 32'(exp_wr.size()), 32'(0));

        // 4: rx_irq coincident with WRITE
        rx_data = 8'h5C;
        go(2, 1'b0);
        k = 0;
        while (!(bus.csr_we && bus.csr_a == 14'h0) && k < 20) begin
            tick();
            k++;
        end
        bus.rx_irq = 1'b1;
        exp_rx.push_back(8'h5C);
        tick();
        bus.rx_irq = 1'b0;
        k = 1;
        while (!rx_valid && k < 10) begin
            tick();
            k++;
        end
        chk("t4 rx latency", 32'(k), 32'(3));
        wait_idle(300, "t4 idle");
        chk("t4 rx left", 32'(exp_rx.size()), 32'(0));

        // 5: abort in WAIT_TX of byte 2 of 5, then restart from 0
        go(5, 1'b0);
        n = 0;
        k = 0;
        while (n < 2 && k < 200) begin
            if (bus.csr_we) n++;
            if (n < 2) tick();
            k++;
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5 abort idle", 32'(busy), 32'(0));
        chk("t5 writes left", 32'(exp_wr.size()), 32'(3));
        flush();
        repeat (20) tick();
        go(5, 1'b0);
        wait_idle(400, "t5 idle");
        chk("t5 writes left 2", 32'(exp_wr.size()), 32'(0));

        // 6: full-size image, addresses 0..15
        tx_lat = 2;
        go(16, 1'b0);
        wait_idle(800, "t6 idle");
        chk("t6 addrs left", 32'(exp_addr.size()), 32'(0));
        chk("t6 done left", 32'(exp_done.size()), 32'(0));

        // 7: async reset mid-stream, restart from 0
        go(4, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t7 rst busy", 32'(busy), 32'(0));
        chk("t7 rst csr_we", 32'(bus.csr_we), 32'(0));
        flush();
        tick();
        rst_n = 1'b1;
        tick();
        go(2, 1'b0);
        wait_idle(300, "t7 idle");
        chk("t7 writes left", 32'(exp_wr.size()), 32'(0));

`ifdef UART_TX_TIMEOUT_EN
        // 8: watchdog with tx_irq withheld
        tx_off = 1'b1;
        go(1, 1'b0);
        k = 0;
        while (!bus.csr_we && k < 20) begin
            tick();
            k++;
        end
        exp_done.delete();
        k = 0;
        while (!err_to && k < 200) begin
            tick();
            k++;
        end
        chk("t8 timeout cycle", 32'(k), 32'(65));
        chk("t8 idle", 32'(busy), 32'(0));
        tx_off = 1'b0;
        go(1, 1'b0);
        chk("t8 err cleared", 32'(err_to), 32'(0));
        wait_idle(100, "t8 idle2");
`else
        chk("err_to tied", 32'(err_to), 32'(0));
`endif

        repeat (10) tick();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
